rv_inst_encoder_loader: RTL

Sequential RV32I instruction encoder and program loader, the inverse of the instruction decode/control path. It accepts instruction fields (opcode, registers, func3, func7 bit 30, immediate) over a valid/ready handshake. It packs them into 32-bit RV32I words per format (R/I/S/B/U/J) and writes them consecutively into instruction memory. Testbenches and boot logic use it to fill instruction memory before the single-cycle core runs.

---
 rtl/rv_inst_encoder_loader_if.sv | 29 ++
 rtl/rv_inst_encoder_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus of the RV32I encoder/loader.
// The master drives instruction fields; the slave (encoder) drives ready and the write port.
interface rv_inst_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic              in_func7b;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7b, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7b, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_inst_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and writes them consecutively
// into instruction memory, one word per two cycles, starting at BASE_ADDR each session.
module rv_inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  rv_inst_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              last_reg;

  logic [31:0]       enc_word;
  logic              enc_bad;
  logic              handshake;
  logic [ADDR_W:0]   count_inc;

  assign count_inc = count_reg + 1'b1;
  assign handshake = (state_reg == ACCEPT) && bus.in_valid && !start;

  always_comb begin
    enc_word = 32'd0;
    enc_bad  = 1'b0;
    case (bus.in_opcode)
      7'b0110011: enc_word = {1'b0, bus.in_func7b, 5'b00000, bus.in_rs2, bus.in_rs1,
                              bus.in_func3, bus.in_rd, bus.in_opcode};
      7'b0010011: begin
        // Shifts reuse the imm[11:5] slot for the arithmetic/logical selector bit.
        if (bus.in_func3 == 3'b001 || bus.in_func3 == 3'b101)
          enc_word = {1'b0, bus.in_func7b, 5'b00000, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_func3, bus.in_rd, bus.in_opcode};
        else
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, bus.in_opcode};
      end
      7'b0000011, 7'b1100111:
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, bus.in_opcode};
      7'b0100011:
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                    bus.in_imm[4:0], bus.in_opcode};
      7'b1100011: begin
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                    bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        enc_bad  = bus.in_imm[0];
      end
      7'b0110111, 7'b0010111:
        enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      7'b1101111: begin
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, bus.in_opcode};
        enc_bad  = bus.in_imm[0];
      end
      default: enc_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ACCEPT;
    end else begin
      case (state_reg)
        ACCEPT: if (bus.in_valid) state_next = enc_bad ? ERROR : WRITE;
        WRITE: begin
          if (last_reg)                    state_next = DONE;
          else if (count_inc == DEPTH_C)   state_next = ERROR;
          else                             state_next = ACCEPT;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // The write address is the implicit pointer BASE_ADDR + count, captured at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      last_reg  <= 1'b0;
    end else if (start) begin
      count_reg <= '0;
    end else if (handshake && !enc_bad) begin
      addr_reg  <= BASE_C + count_reg[ADDR_W-1:0];
      wdata_reg <= enc_word;
      last_reg  <= bus.in_last;
    end else if (state_reg == WRITE) begin
      count_reg <= count_inc;
    end
  end

  always_comb begin
    bus.in_ready  = (state_reg == ACCEPT);
    bus.mem_we    = (state_reg == WRITE) && !start;
    bus.mem_addr  = addr_reg;
    bus.mem_wdata = wdata_reg;
    busy          = (state_reg == ACCEPT) || (state_reg == WRITE);
    done          = (state_reg == DONE);
    err           = (state_reg == ERROR);
    count         = count_reg;
  end

endmodule
